// File: rtl/fifo_modport.sv
// Single-clock 32x32 synchronous FIFO with write-side status (level, free count, almost-full, overflow).
// Optional macro FIFO_STICKY_OVF_EN makes overflow/underflow sticky until hw_rst or sw_rst.
module fifo_modport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  wclk,
    input  logic                  hw_rst,
    input  logic                  mem_rst,
    input  logic                  sw_rst,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] afull_value,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  wr_almost_ful,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fifo_write_count,
    output logic [ADDR_WIDTH:0]   wr_level
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic [ADDR_WIDTH:0]   r_free;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ovf_evt;
    logic                  w_udf_evt;
    logic [ADDR_WIDTH:0]   w_level_nxt;

    // Acceptance is judged on the registered flags, so a full FIFO still takes a read but drops the write.
    assign w_wr_acc  = write_enable & ~r_full & ~sw_rst & ~mem_rst;
    assign w_rd_acc  = read_enable & ~r_empty & ~sw_rst;
    assign w_ovf_evt = write_enable & r_full;
    assign w_udf_evt = read_enable & r_empty;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // NOTE: storage has no async reset; only the synchronous mem_rst clears it, keeping it RAM-mappable.
    always_ff @(posedge wclk) begin
        if (mem_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // NOTE: all state uses non-blocking assignments so every flag sees pre-edge values of its peers.
    always_ff @(posedge wclk or posedge hw_rst) begin
        if (hw_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_free   <= C_DEPTH;
            r_rdata  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (sw_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_free   <= C_DEPTH;
            r_rdata  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rdata  <= r_mem[r_rd_ptr];
            end
            r_level <= w_level_nxt;
            r_free  <= C_DEPTH - w_level_nxt;
            r_full  <= (w_level_nxt == C_DEPTH);
            r_empty <= (w_level_nxt == '0);
            r_afull <= (afull_value != '0) && (w_level_nxt >= {1'b0, afull_value});
`ifdef FIFO_STICKY_OVF_EN
            r_ovf   <= r_ovf | w_ovf_evt;
            r_udf   <= r_udf | w_udf_evt;
`else
            r_ovf   <= w_ovf_evt;
            r_udf   <= w_udf_evt;
`endif
        end
    end

    assign rdata            = r_rdata;
    assign wfull            = r_full;
    assign rempty           = r_empty;
    assign wr_almost_ful    = r_afull;
    assign overflow         = r_ovf;
    assign underflow        = r_udf;
    assign fifo_write_count = r_free;
    assign wr_level         = r_level;

endmodule

// File: tb/tb_fifo_modport.sv
// Scoreboard bench for fifo_modport: stimulus pushes expected read data, a monitor pops and compares.
module tb_fifo_modport;

`ifdef FIFO_STICKY_OVF_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        wclk = 1'b0;
    logic        hw_rst;
    logic        mem_rst;
    logic        sw_rst;
    logic [31:0] wdata;
    logic        write_enable;
    logic [4:0]  afull_value;
    logic        read_enable;
    logic [31:0] rdata;
    logic        wfull;
    logic        rempty;
    logic        wr_almost_ful;
    logic        overflow;
    logic        underflow;
    logic [5:0]  fifo_write_count;
    logic [5:0]  wr_level;

    fifo_modport dut (
        .wclk             (wclk),
        .hw_rst           (hw_rst),
        .mem_rst          (mem_rst),
        .sw_rst           (sw_rst),
        .wdata            (wdata),
        .write_enable     (write_enable),
        .afull_value      (afull_value),
        .read_enable      (read_enable),
        .rdata            (rdata),
        .wfull            (wfull),
        .rempty           (rempty),
        .wr_almost_ful    (wr_almost_ful),
        .overflow         (overflow),
        .underflow        (underflow),
        .fifo_write_count (fifo_write_count),
        .wr_level         (wr_level)
    );

    always #5 wclk = ~wclk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_q[$];
    logic [31:0] exp_q[$];
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;
    logic [31:0] m_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input string tag);
        int lvl;
        lvl = m_q.size();
        check({tag, ".wr_level"},  32'(wr_level), 32'(lvl));
        check({tag, ".wcount"},    32'(fifo_write_count), 32'(32 - lvl));
        check({tag, ".wfull"},     32'(wfull), 32'(lvl == 32));
        check({tag, ".rempty"},    32'(rempty), 32'(lvl == 0));
        check({tag, ".afull"},     32'(wr_almost_ful), 32'((afull_value != 0) && (lvl >= int'(afull_value))));
        check({tag, ".overflow"},  32'(overflow), 32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
        check({tag, ".rdata"},     rdata, m_rdata);
    endtask

    // One clock of stimulus; the model decides acceptance from its pre-edge state.
    task automatic cyc(input bit we, input logic [31:0] wd, input bit re, input bit sw, input bit mr);
        bit full;
        bit empty;
        full  = (m_q.size() == 32);
        empty = (m_q.size() == 0);
        write_enable = we;
        wdata        = wd;
        read_enable  = re;
        sw_rst       = sw;
        mem_rst      = mr;
        if (sw) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_rdata = '0;
        end else begin
            if (re && !empty) begin
                m_rdata = m_q.pop_front();
                exp_q.push_back(m_rdata);
            end
            if (mr) begin
                foreach (m_q[i]) m_q[i] = '0;
            end
            if (we && !full && !mr) m_q.push_back(wd);
            m_ovf = STICKY ? (m_ovf | (we && full)) : (we && full);
            m_udf = STICKY ? (m_udf | (re && empty)) : (re && empty);
        end
        @(posedge wclk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        sw_rst       = 1'b0;
        mem_rst      = 1'b0;
        check_status("cyc");
    endtask

    task automatic wr(input logic [31:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: whenever the DUT accepts a read, compare rdata after the edge with the scoreboard head.
    initial begin
        logic [31:0] exp_d;
        forever begin
            @(negedge wclk);
            if (!hw_rst && !sw_rst && read_enable && !rempty) begin
                @(posedge wclk);
                #2;
                if (exp_q.size() == 0) begin
                    check("mon.unexpected_read", rdata, 32'hFFFF_FFFF);
                end else begin
                    exp_d = exp_q.pop_front();
                    check("mon.rdata", rdata, exp_d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hw_rst       = 1'b1;
        mem_rst      = 1'b0;
        sw_rst       = 1'b0;
        wdata        = '0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        afull_value  = 5'd28;
        repeat (2) @(posedge wclk);
        #1;
        hw_rst = 1'b0;
        check_status("reset");
        check("reset.wcount_const", 32'(fifo_write_count), 32'd32);

        // Async hw_rst mid-cycle with 7 entries held.
        for (int i = 0; i < 7; i++) wr(32'hA0 + 32'(i));
        check("pre_hwrst.level", 32'(wr_level), 32'd7);
        #2;
        hw_rst = 1'b1;
        #1;
        m_q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_rdata = '0;
        check_status("hwrst_async");
        check("hwrst_async.level_const", 32'(wr_level), 32'd0);
        @(posedge wclk);
        #1;
        hw_rst = 1'b0;

        // Fill with almost-full threshold 28, then one write too many.
        for (int i = 1; i <= 32; i++) begin
            wr(32'(i));
            if (i == 27) check("fill27.afull", 32'(wr_almost_ful), 32'd0);
            if (i == 28) check("fill28.afull", 32'(wr_almost_ful), 32'd1);
        end
        check("fill32.wfull", 32'(wfull), 32'd1);
        check("fill32.wcount", 32'(fifo_write_count), 32'd0);
        wr(32'h21);
        check("fill33.overflow", 32'(overflow), 32'd1);
        check("fill33.level", 32'(wr_level), 32'd32);
        idle(1);
        check("fill33.ovf_after", 32'(overflow), 32'(STICKY));

        // Drain in order, then exercise pointer wrap.
        for (int i = 0; i < 32; i++) rd();
        check("drain.rdata_last", rdata, 32'h20);
        for (int i = 0; i < 25; i++) wr(32'h100 + 32'(i));
        for (int i = 0; i < 25; i++) rd();
        for (int i = 0; i < 10; i++) wr(32'h200 + 32'(i));
        for (int i = 0; i < 10; i++) rd();
        check("wrap.rdata_last", rdata, 32'h209);
        rd();
        check("empty_rd.underflow", 32'(underflow), 32'd1);
        check("empty_rd.rdata_hold", rdata, 32'h209);
        idle(1);

        // Simultaneous read+write at level 5.
        for (int i = 0; i < 5; i++) wr(32'h300 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h310 + 32'(i), 1'b1, 1'b0, 1'b0);
            check("simul.level", 32'(wr_level), 32'd5);
        end
        for (int i = 0; i < 5; i++) rd();
        check("simul.rdata_last", rdata, 32'h313);

        // Read+write on empty: only the write lands.
        cyc(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
        check("empty_rw.underflow", 32'(underflow), 32'd1);
        check("empty_rw.level", 32'(wr_level), 32'd1);
        rd();

        // Read+write on full: only the read lands.
        for (int i = 0; i < 32; i++) wr(32'h500 + 32'(i));
        cyc(1'b1, 32'h5FF, 1'b1, 1'b0, 1'b0);
        check("full_rw.level", 32'(wr_level), 32'd31);
        check("full_rw.overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 31; i++) rd();

        // sw_rst at level 12.
        for (int i = 0; i < 12; i++) wr(32'h600 + 32'(i));
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("swrst.level", 32'(wr_level), 32'd0);
        check("swrst.rempty", 32'(rempty), 32'd1);

        // mem_rst at level 3 with a write that must be ignored; almost-full threshold changes live.
        for (int i = 0; i < 3; i++) wr(32'hDEAD_0000 + 32'(i));
        cyc(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b1);
        check("memrst.level", 32'(wr_level), 32'd3);
        afull_value = 5'd2;
        idle(1);
        check("afull2.flag", 32'(wr_almost_ful), 32'd1);
        afull_value = 5'd0;
        idle(1);
        check("afull0.flag", 32'(wr_almost_ful), 32'd0);
        afull_value = 5'd28;
        rd();
        check("memrst.rdata0", rdata, 32'h0);
        rd();
        rd();

        // Overflow persistence: one rejected write, idle, then sw_rst.
        for (int i = 0; i < 32; i++) wr(32'h700 + 32'(i));
        wr(32'h7FF);
        idle(5);
        check("sticky.ovf_idle", 32'(overflow), 32'(STICKY));
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("sticky.ovf_cleared", 32'(overflow), 32'd0);

        idle(2);
        check("scoreboard.drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
